// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller: FSM states,
// the per-register control bundle and the common RUN-state decision rule.
package hazard_pkg;

  localparam int STATE_W        = 2;
  localparam int CNT_W_DEF      = 16;
  localparam int EX_TIMEOUT_DEF = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_EX_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic exmem_flush;
    logic memwb_write;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET    = 8'b0010_1010;
  localparam ctrl_t CTRL_RUN      = 8'b1101_0101;
  localparam ctrl_t CTRL_HOLD     = 8'b0000_0000;
  localparam ctrl_t CTRL_BRANCH   = 8'b1111_1101;
  localparam ctrl_t CTRL_LOAD_USE = 8'b0001_1101;
  // Front end frozen, bubble pushed into MEM, older instruction retires.
  localparam ctrl_t CTRL_EX_STALL = 8'b0000_0111;

  typedef struct packed {
    ctrl_t  ctrl;
    state_t next;
    logic   ex_enter;
  } decision_t;

  // RUN rules by priority; MEM_WAIT reuses them on the cycle memory releases.
  function automatic decision_t run_rules(input logic mem_busy, input logic mc_start,
                                          input logic mc_done, input logic branch_taken,
                                          input logic load_use);
    decision_t d;
    d.ctrl     = CTRL_RUN;
    d.next     = ST_RUN;
    d.ex_enter = 1'b0;
    if (mem_busy) begin
      d.ctrl = CTRL_HOLD;
      d.next = ST_MEM_WAIT;
    end else if (mc_start && !mc_done) begin
      d.ctrl     = CTRL_EX_STALL;
      d.next     = ST_EX_WAIT;
      d.ex_enter = 1'b1;
    end else if (branch_taken) begin
      d.ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      d.ctrl = CTRL_LOAD_USE;
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard information from the pipeline and per-register controls back to it.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic             ex_mc_start;
  logic             ex_mc_done;
  logic             mem_busy;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             memwb_write;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             ex_timeout;
  logic [1:0]       state_o;

  // Pipeline side.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, ex_mc_start, ex_mc_done, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, memwb_write, stall_cnt, flush_cnt,
           ex_timeout, state_o
  );

  // Hazard controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, ex_mc_start, ex_mc_done, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, memwb_write, stall_cnt, flush_cnt,
           ex_timeout, state_o
  );

endinterface

// File: rtl/hz_sat_counter.sv
// Saturating event counter: sticks at all-ones, synchronous clear wins over increment.
module hz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy write/flush decode for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB, with EX/MEM wait states and stall/flush statistics.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EX_TIMEOUT = EX_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(EX_TIMEOUT);

  state_t    r_state;
  logic [7:0] r_wait_cnt;
  logic      r_ex_timeout;

  state_t    w_next_state;
  logic [7:0] w_wait_next;
  logic      w_timeout_set;
  logic      w_load_use;
  ctrl_t     w_ctrl;
  decision_t w_run;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign w_load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  assign w_run = run_rules(hz.mem_busy, hz.ex_mc_start, hz.ex_mc_done,
                           hz.ex_branch_taken, w_load_use);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_ctrl        = CTRL_HOLD;
    w_next_state  = r_state;
    w_wait_next   = r_wait_cnt;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        w_ctrl       = w_run.ctrl;
        w_next_state = w_run.next;
        if (w_run.ex_enter) w_wait_next = 8'd1;
      end
      ST_EX_WAIT: begin
        if (hz.mem_busy) begin
          w_ctrl = CTRL_HOLD;
        end else if (hz.ex_mc_done) begin
          w_ctrl       = CTRL_RUN;
          w_next_state = ST_RUN;
        end else if (r_wait_cnt == TIMEOUT_VAL) begin
          w_timeout_set = 1'b1;
          w_ctrl        = CTRL_RUN;
          w_next_state  = ST_RUN;
        end else begin
          w_ctrl      = CTRL_EX_STALL;
          w_wait_next = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_ctrl       = CTRL_HOLD;
        w_next_state = ST_RUN;
      end
    endcase
    if (!reset) w_ctrl = CTRL_RESET;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_wait_cnt   <= 8'd0;
      r_ex_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      if (w_timeout_set) r_ex_timeout <= 1'b1;
    end
  end

  assign hz.pc_write    = w_ctrl.pc_write;
  assign hz.ifid_write  = w_ctrl.ifid_write;
  assign hz.ifid_flush  = w_ctrl.ifid_flush;
  assign hz.idex_write  = w_ctrl.idex_write;
  assign hz.idex_flush  = w_ctrl.idex_flush;
  assign hz.exmem_write = w_ctrl.exmem_write;
  assign hz.exmem_flush = w_ctrl.exmem_flush;
  assign hz.memwb_write = w_ctrl.memwb_write;
  assign hz.ex_timeout  = r_ex_timeout;
  assign hz.state_o     = r_state;

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clear (!reset),
    .i_inc   (!w_ctrl.pc_write),
    .o_count (hz.stall_cnt)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .i_clear (!reset),
    .i_inc   (w_ctrl.ifid_flush || w_ctrl.idex_flush),
    .o_count (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vectors for hazard_ctrl; a driver queues expectations, a negedge monitor checks them.
module tb_hazard_ctrl;

  localparam int CNT_W      = 4;
  localparam int EX_TIMEOUT = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  // Expected control bundles: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w}
  localparam logic [7:0] E_RST  = 8'b0010_1010;
  localparam logic [7:0] E_RUN  = 8'b1101_0101;
  localparam logic [7:0] E_HOLD = 8'b0000_0000;
  localparam logic [7:0] E_BR   = 8'b1111_1101;
  localparam logic [7:0] E_LU   = 8'b0001_1101;
  localparam logic [7:0] E_EXW  = 8'b0000_0111;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mr, br, mcs, mcd, busy;
    logic [7:0] ctrl;
    logic [1:0] st;
    logic       tmo;
    bit         chk;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W), .EX_TIMEOUT(EX_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  vec_t stim[$];
  vec_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  logic [4:0] g_rs1, g_rs2, g_rd;
  logic       g_use1, g_use2;

  function void regs(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic use1, input logic use2);
    g_rs1 = rs1; g_rs2 = rs2; g_rd = rd; g_use1 = use1; g_use2 = use2;
  endfunction

  function void add(input string name, input logic rst_n, input logic mr, input logic br,
                    input logic mcs, input logic mcd, input logic busy, input logic [7:0] ctrl,
                    input logic [1:0] st, input logic tmo, input bit chk);
    vec_t v;
    v.name = name; v.rst_n = rst_n;
    v.rs1 = g_rs1; v.rs2 = g_rs2; v.rd = g_rd; v.use1 = g_use1; v.use2 = g_use2;
    v.mr = mr; v.br = br; v.mcs = mcs; v.mcd = mcd; v.busy = busy;
    v.ctrl = ctrl; v.st = st; v.tmo = tmo; v.chk = chk;
    stim.push_back(v);
  endfunction

  task automatic check(input string name, input string what,
                       input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s %s: got %0h expected %0h", name, what, got, exp);
  endtask

  task automatic apply(input vec_t v);
    reset              = v.rst_n;
    hz.id_rs1          = v.rs1;
    hz.id_rs2          = v.rs2;
    hz.id_use_rs1      = v.use1;
    hz.id_use_rs2      = v.use2;
    hz.ex_rd           = v.rd;
    hz.ex_memread      = v.mr;
    hz.ex_branch_taken = v.br;
    hz.ex_mc_start     = v.mcs;
    hz.ex_mc_done      = v.mcd;
    hz.mem_busy        = v.busy;
  endtask

  // Monitor: registered outputs are checked against the count model built from expected controls.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t v;
      logic [7:0] got;
      v   = exp_q.pop_front();
      got = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write, hz.idex_flush,
             hz.exmem_write, hz.exmem_flush, hz.memwb_write};
      check(v.name, "ctrl", 16'(got), 16'(v.ctrl));
      if (v.chk) begin
        check(v.name, "state", 16'(hz.state_o), 16'(v.st));
        check(v.name, "stall_cnt", 16'(hz.stall_cnt), 16'(m_stall));
        check(v.name, "flush_cnt", 16'(hz.flush_cnt), 16'(m_flush));
        check(v.name, "ex_timeout", 16'(hz.ex_timeout), 16'(v.tmo));
      end
      if (!v.rst_n) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!v.ctrl[7] && m_stall < CNT_MAX) m_stall++;
        if ((v.ctrl[5] || v.ctrl[3]) && m_flush < CNT_MAX) m_flush++;
      end
    end
  end

  initial begin
    regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    // reset: forced stall/flush outputs, registers cleared by the second cycle
    add("rst0", 0, 1, 0, 0, 0, 0, E_RST, 2'd0, 0, 0);
    add("rst1", 0, 1, 0, 0, 0, 0, E_RST, 2'd0, 0, 1);
    add("idle", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    // load-use on rs2, then on rs1, plus the non-hazard boundaries
    regs(5'd3, 5'd5, 5'd5, 1'b1, 1'b1);
    add("lu_rs2",        1, 1, 0, 0, 0, 0, E_LU,  2'd0, 0, 1);
    add("lu_rs2_bubble", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    regs(5'd0, 5'd7, 5'd0, 1'b1, 1'b0);
    add("lu_rd0",        1, 1, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    regs(5'd9, 5'd4, 5'd9, 1'b0, 1'b1);
    add("lu_unused_src", 1, 1, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    regs(5'd9, 5'd4, 5'd9, 1'b1, 1'b0);
    add("no_load",       1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    add("lu_rs1",        1, 1, 0, 0, 0, 0, E_LU,  2'd0, 0, 1);
    add("lu_rs1_bubble", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    // taken branch, alone and over a load-use
    regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    add("branch",     1, 0, 1, 0, 0, 0, E_BR,  2'd0, 0, 1);
    add("br_after",   1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    regs(5'd6, 5'd0, 5'd6, 1'b1, 1'b0);
    add("br_over_lu", 1, 1, 1, 0, 0, 0, E_BR,  2'd0, 0, 1);
    regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    add("br_over_lu_after", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    // multi-cycle EX finishing on the 4th wait cycle; done beats timeout at the limit
    add("mc_start", 1, 0, 0, 1, 0, 0, E_EXW, 2'd0, 0, 1);
    add("mc_wait1", 1, 0, 0, 1, 0, 0, E_EXW, 2'd1, 0, 1);
    add("mc_wait2", 1, 0, 0, 1, 0, 0, E_EXW, 2'd1, 0, 1);
    add("mc_wait3", 1, 0, 0, 1, 0, 0, E_EXW, 2'd1, 0, 1);
    add("mc_done",  1, 0, 0, 1, 1, 0, E_RUN, 2'd1, 0, 1);
    add("mc_back",  1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    add("mc_1cyc",  1, 0, 0, 1, 1, 0, E_RUN, 2'd0, 0, 1);
    // memory wait hiding a taken branch, which flushes on release
    add("mb0",      1, 0, 1, 0, 0, 1, E_HOLD, 2'd0, 0, 1);
    add("mb1",      1, 0, 1, 0, 0, 1, E_HOLD, 2'd2, 0, 1);
    add("mb2",      1, 0, 1, 0, 0, 1, E_HOLD, 2'd2, 0, 1);
    add("mb_rel",   1, 0, 1, 0, 0, 0, E_BR,   2'd2, 0, 1);
    add("mb_after", 1, 0, 0, 0, 0, 0, E_RUN,  2'd0, 0, 1);
    // memory stall inside EX_WAIT freezes the wait counter
    add("fz_start", 1, 0, 0, 1, 0, 0, E_EXW,  2'd0, 0, 1);
    add("fz_w1",    1, 0, 0, 1, 0, 0, E_EXW,  2'd1, 0, 1);
    add("fz_busy0", 1, 0, 0, 1, 0, 1, E_HOLD, 2'd1, 0, 1);
    add("fz_busy1", 1, 0, 0, 1, 0, 1, E_HOLD, 2'd1, 0, 1);
    add("fz_w2",    1, 0, 0, 1, 0, 0, E_EXW,  2'd1, 0, 1);
    add("fz_w3",    1, 0, 0, 1, 0, 0, E_EXW,  2'd1, 0, 1);
    add("fz_done",  1, 0, 0, 1, 1, 0, E_RUN,  2'd1, 0, 1);
    add("fz_back",  1, 0, 0, 0, 0, 0, E_RUN,  2'd0, 0, 1);
    // no done: forced release after EX_TIMEOUT wait cycles, sticky flag
    add("to_start", 1, 0, 0, 1, 0, 0, E_EXW, 2'd0, 0, 1);
    add("to_w1",    1, 0, 0, 1, 0, 0, E_EXW, 2'd1, 0, 1);
    add("to_w2",    1, 0, 0, 1, 0, 0, E_EXW, 2'd1, 0, 1);
    add("to_w3",    1, 0, 0, 1, 0, 0, E_EXW, 2'd1, 0, 1);
    add("to_fire",  1, 0, 0, 1, 0, 0, E_RUN, 2'd1, 0, 1);
    add("to_after", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 1, 1);
    regs(5'd2, 5'd0, 5'd2, 1'b1, 1'b0);
    add("to_sticky_lu", 1, 1, 0, 0, 0, 0, E_LU,  2'd0, 1, 1);
    add("to_sticky",    1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 1, 1);
    regs(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    add("rst2a",    0, 1, 0, 0, 0, 0, E_RST, 2'd0, 1, 1);
    add("rst2b",    0, 1, 0, 0, 0, 0, E_RST, 2'd0, 0, 1);
    add("post_rst", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    // saturation of both statistics counters
    add("sat_busy", 1, 0, 0, 0, 0, 1, E_HOLD, 2'd0, 0, 1);
    for (int i = 0; i < 17; i++) add("sat_hold", 1, 0, 0, 0, 0, 1, E_HOLD, 2'd2, 0, 1);
    add("sat_rel",  1, 0, 0, 0, 0, 0, E_RUN, 2'd2, 0, 1);
    add("sat_schk", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);
    for (int i = 0; i < 17; i++) add("sat_br", 1, 0, 1, 0, 0, 0, E_BR, 2'd0, 0, 1);
    add("sat_fchk", 1, 0, 0, 0, 0, 0, E_RUN, 2'd0, 0, 1);

    apply(stim[0]);
    foreach (stim[i]) begin
      @(posedge clk);
      #1;
      apply(stim[i]);
      exp_q.push_back(stim[i]);
    end
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d vectors unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
